hcordic_packet_issuer: RTL and testbench

HCORDIC_PACKET_ISSUER -- requirements
Module: hcordic_packet_issuer

---
 rtl/hcordic_packet_issuer.sv | 170 +++++++++++++++++
 tb/tb_hcordic_packet_issuer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcordic_packet_issuer.sv
`default_nettype none
// ============================================================================
// Module      : hcordic_packet_issuer
// Description : Accepts a CORDIC job, serialises it as seven 16-bit packet
//               words to the HCORDIC pipeline, then waits for the pipeline
//               result (or a timeout) and holds it until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module hcordic_packet_issuer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_x,
  input  logic [31:0] job_y,
  input  logic [31:0] job_z,
  input  logic [1:0]  job_mode,
  input  logic        job_operation,
  output logic [15:0] InstructionPacket,
  input  logic [31:0] x_out,
  input  logic [31:0] y_out,
  input  logic [31:0] z_out,
  input  logic        done,
  output logic [31:0] res_x,
  output logic [31:0] res_y,
  output logic [31:0] res_z,
  output logic        res_valid,
  output logic        res_timeout,
  input  logic        res_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam logic [15:0] c_timeout  = 16'(TIMEOUT);
  localparam logic [2:0]  c_last_idx = 3'd6;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_idx;
  logic [15:0] r_cnt;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_z;
  logic [1:0]  r_mode;
  logic        r_op;
  logic [15:0] r_packet;
  logic [15:0] w_word;
  logic [31:0] r_res_x;
  logic [31:0] r_res_y;
  logic [31:0] r_res_z;
  logic        r_res_valid;
  logic        r_res_timeout;
  logic        w_timeout_hit;

  assign job_ready         = (r_state == IDLE) && !reset;
  assign InstructionPacket = r_packet;
  assign res_x             = r_res_x;
  assign res_y             = r_res_y;
  assign res_z             = r_res_z;
  assign res_valid         = r_res_valid;
  assign res_timeout       = r_res_timeout;
  assign w_timeout_hit     = (r_cnt == c_timeout);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; done outranks the timeout in WAIT.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (job_valid)                 w_next_state = SEND;
      SEND:    if (r_idx == c_last_idx)       w_next_state = WAIT;
      WAIT:    if (done || w_timeout_hit)     w_next_state = RESULT;
      RESULT:  if (r_res_valid && res_ready)  w_next_state = IDLE;
      default:                                w_next_state = IDLE;
    endcase
  end

  // Select the packet word for the current index from the registered job.
  always_comb begin
    w_word = 16'h0000;
    case (r_idx)
      3'd0:    w_word = {4'hA, 9'b0, r_op, r_mode};
      3'd1:    w_word = r_x[31:16];
      3'd2:    w_word = r_x[15:0];
      3'd3:    w_word = r_y[31:16];
      3'd4:    w_word = r_y[15:0];
      3'd5:    w_word = r_z[31:16];
      3'd6:    w_word = r_z[15:0];
      default: w_word = 16'h0000;
    endcase
  end

  // Job capture, packet output, wait counter and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx         <= 3'd0;
      r_cnt         <= 16'd0;
      r_x           <= 32'd0;
      r_y           <= 32'd0;
      r_z           <= 32'd0;
      r_mode        <= 2'd0;
      r_op          <= 1'b0;
      r_packet      <= 16'h0000;
      r_res_x       <= 32'd0;
      r_res_y       <= 32'd0;
      r_res_z       <= 32'd0;
      r_res_valid   <= 1'b0;
      r_res_timeout <= 1'b0;
    end else begin
      r_packet <= (r_state == SEND) ? w_word : 16'h0000;
      case (r_state)
        IDLE: begin
          if (job_valid) begin
            r_x    <= job_x;
            r_y    <= job_y;
            r_z    <= job_z;
            r_mode <= job_mode;
            r_op   <= job_operation;
            r_idx  <= 3'd0;
          end
        end
        SEND: begin
          if (r_idx == c_last_idx) begin
            r_idx <= 3'd0;
            r_cnt <= 16'd0;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        WAIT: begin
          if (done) begin
            r_res_x       <= x_out;
            r_res_y       <= y_out;
            r_res_z       <= z_out;
            r_res_valid   <= 1'b1;
            r_res_timeout <= 1'b0;
          end else if (w_timeout_hit) begin
            r_res_x       <= 32'd0;
            r_res_y       <= 32'd0;
            r_res_z       <= 32'd0;
            r_res_valid   <= 1'b1;
            r_res_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RESULT: begin
          if (r_res_valid && res_ready) begin
            r_res_valid   <= 1'b0;
            r_res_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hcordic_packet_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hcordic_packet_issuer
// Description : Directed self-checking bench for hcordic_packet_issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hcordic_packet_issuer;

  logic        clock;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_x, job_y, job_z;
  logic [1:0]  job_mode;
  logic        job_operation;
  logic [15:0] InstructionPacket;
  logic [31:0] x_out, y_out, z_out;
  logic        done;
  logic [31:0] res_x, res_y, res_z;
  logic        res_valid, res_timeout, res_ready;

  int n_vec;
  int n_err;

  hcordic_packet_issuer #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_y(job_y), .job_z(job_z),
    .job_mode(job_mode), .job_operation(job_operation),
    .InstructionPacket(InstructionPacket),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .done(done),
    .res_x(res_x), .res_y(res_y), .res_z(res_z),
    .res_valid(res_valid), .res_timeout(res_timeout), .res_ready(res_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a job for one accept edge, then scramble the job inputs.
  task automatic start_job(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic [1:0] m, input logic op);
    job_x = x; job_y = y; job_z = z; job_mode = m; job_operation = op;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    job_x = 32'hDEADDEAD; job_y = 32'hBEEFBEEF; job_z = 32'h55555555;
    job_mode = ~m; job_operation = ~op;
  endtask

  task automatic test_reset();
    reset = 1'b1; job_valid = 1'b0; res_ready = 1'b0; done = 1'b0;
    job_x = '0; job_y = '0; job_z = '0; job_mode = '0; job_operation = 1'b0;
    x_out = '0; y_out = '0; z_out = '0;
    tick(); tick();
    n_vec++;
    if ({job_ready, InstructionPacket, res_valid, res_timeout, res_x, res_y, res_z} !== 115'd0) begin
      n_err++;
      $display("FAIL reset_state: got ready=%b pkt=%h v=%b t=%b x=%h y=%h z=%h want all zero",
               job_ready, InstructionPacket, res_valid, res_timeout, res_x, res_y, res_z);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (job_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: got %b want 1", job_ready);
    end
  endtask

  // Packet sequence with done pulses during IDLE and SEND that must be ignored.
  task automatic test_packets();
    logic [15:0] exp_w [0:6];
    exp_w[0] = 16'hA005; exp_w[1] = 16'h1234; exp_w[2] = 16'h5678; exp_w[3] = 16'h9ABC;
    exp_w[4] = 16'hDEF0; exp_w[5] = 16'h0F0F; exp_w[6] = 16'h0F0F;
    done = 1'b1; x_out = 32'h11111111; y_out = 32'h22222222; z_out = 32'h33333333;
    tick();
    n_vec++;
    if (res_valid !== 1'b0) begin
      n_err++; $display("FAIL done_in_idle: res_valid got %b want 0", res_valid);
    end
    start_job(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 2'b01, 1'b1);
    n_vec++;
    if (InstructionPacket !== 16'h0000 || job_ready !== 1'b0) begin
      n_err++; $display("FAIL accept_cycle: pkt=%h ready=%b want 0000/0", InstructionPacket, job_ready);
    end
    for (int k = 0; k < 7; k++) begin
      done = (k % 2 == 0) && (k < 6);
      tick();
      n_vec++;
      if (InstructionPacket !== exp_w[k] || res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL packet_w%0d: pkt=%h v=%b want %h/0", k, InstructionPacket, res_valid, exp_w[k]);
      end
    end
    done = 1'b0;
    tick();
    n_vec++;
    if (InstructionPacket !== 16'h0000 || res_valid !== 1'b0) begin
      n_err++; $display("FAIL packet_idle_after: pkt=%h v=%b want 0000/0", InstructionPacket, res_valid);
    end
  endtask

  // Data result from WAIT, held 10 cycles, done in RESULT ignored, then consumed.
  task automatic test_data_result();
    done = 1'b1; x_out = 32'h00010000; y_out = 32'h00000000; z_out = 32'hFFFF0000;
    tick();
    done = 1'b0; x_out = 32'hAAAAAAAA; y_out = 32'hBBBBBBBB; z_out = 32'hCCCCCCCC;
    n_vec++;
    if ({res_valid, res_timeout, res_x, res_y, res_z} !== {2'b10, 32'h00010000, 32'h0, 32'hFFFF0000}) begin
      n_err++;
      $display("FAIL data_capture: v=%b t=%b x=%h y=%h z=%h want 1 0 00010000 00000000 ffff0000",
               res_valid, res_timeout, res_x, res_y, res_z);
    end
    for (int k = 0; k < 10; k++) begin
      done = (k == 3);
      tick();
      n_vec++;
      if ({res_valid, res_timeout, res_x, res_y, res_z} !== {2'b10, 32'h00010000, 32'h0, 32'hFFFF0000}) begin
        n_err++;
        $display("FAIL data_hold_%0d: v=%b t=%b x=%h y=%h z=%h", k, res_valid, res_timeout, res_x, res_y, res_z);
      end
    end
    done = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_vec++;
    if ({res_valid, res_timeout, job_ready, res_x} !== {3'b001, 32'h00010000}) begin
      n_err++;
      $display("FAIL data_consume: v=%b t=%b ready=%b x=%h want 0 0 1 00010000",
               res_valid, res_timeout, job_ready, res_x);
    end
  endtask

  // No done: result appears on the 6th cycle after entering WAIT (TIMEOUT=4).
  task automatic test_timeout();
    start_job(32'h00000001, 32'h00000002, 32'h00000003, 2'b00, 1'b0);
    repeat (7) tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_vec++;
      if (res_valid !== 1'b0) begin
        n_err++; $display("FAIL timeout_early_%0d: res_valid got %b want 0", k, res_valid);
      end
    end
    tick();
    n_vec++;
    if ({res_valid, res_timeout, res_x, res_y, res_z} !== {2'b11, 96'd0}) begin
      n_err++;
      $display("FAIL timeout_result: v=%b t=%b x=%h y=%h z=%h want 1 1 0 0 0",
               res_valid, res_timeout, res_x, res_y, res_z);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_vec++;
    if ({res_valid, res_timeout} !== 2'b00) begin
      n_err++; $display("FAIL timeout_consume: v=%b t=%b want 0 0", res_valid, res_timeout);
    end
  endtask

  // done arriving on the counter==TIMEOUT cycle wins over the timeout.
  task automatic test_done_priority();
    start_job(32'h00000004, 32'h00000005, 32'h00000006, 2'b11, 1'b1);
    repeat (7) tick();
    repeat (4) tick();
    done = 1'b1; x_out = 32'h13572468; y_out = 32'h24681357; z_out = 32'h0000FFFF;
    tick();
    done = 1'b0;
    n_vec++;
    if ({res_valid, res_timeout, res_x, res_y, res_z} !== {2'b10, 32'h13572468, 32'h24681357, 32'h0000FFFF}) begin
      n_err++;
      $display("FAIL done_priority: v=%b t=%b x=%h y=%h z=%h want 1 0 13572468 24681357 0000ffff",
               res_valid, res_timeout, res_x, res_y, res_z);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Reset while w3 is on the bus, then a full fresh packet sequence.
  task automatic test_reset_mid_send();
    logic [15:0] exp_w [0:6];
    exp_w[0] = 16'hA002; exp_w[1] = 16'hCAFE; exp_w[2] = 16'hBABE; exp_w[3] = 16'h0123;
    exp_w[4] = 16'h4567; exp_w[5] = 16'h89AB; exp_w[6] = 16'hCDEF;
    start_job(32'h11112222, 32'h33334444, 32'h55556666, 2'b01, 1'b0);
    repeat (4) tick();
    n_vec++;
    if (InstructionPacket !== 16'h3333) begin
      n_err++; $display("FAIL pre_reset_w3: pkt=%h want 3333", InstructionPacket);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({InstructionPacket, res_valid, job_ready} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_mid_send: pkt=%h v=%b ready=%b want 0", InstructionPacket, res_valid, job_ready);
    end
    tick();
    reset = 1'b0;
    start_job(32'hCAFEBABE, 32'h01234567, 32'h89ABCDEF, 2'b10, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      n_vec++;
      if (InstructionPacket !== exp_w[k]) begin
        n_err++; $display("FAIL post_reset_w%0d: pkt=%h want %h", k, InstructionPacket, exp_w[k]);
      end
    end
  endtask

  // Result consumed and a pending job accepted exactly one cycle later.
  task automatic test_back_to_back();
    tick();
    done = 1'b1; x_out = 32'h00000077; y_out = 32'h00000088; z_out = 32'h00000099;
    tick();
    done = 1'b0;
    job_x = 32'h0000AAAA; job_y = 32'h0000BBBB; job_z = 32'h0000CCCC;
    job_mode = 2'b10; job_operation = 1'b1;
    job_valid = 1'b1; res_ready = 1'b1;
    n_vec++;
    if ({res_valid, res_x} !== {1'b1, 32'h00000077}) begin
      n_err++; $display("FAIL b2b_result: v=%b x=%h want 1 00000077", res_valid, res_x);
    end
    tick();
    n_vec++;
    if ({res_valid, job_ready, InstructionPacket} !== {2'b01, 16'h0000}) begin
      n_err++;
      $display("FAIL b2b_consume: v=%b ready=%b pkt=%h want 0 1 0000", res_valid, job_ready, InstructionPacket);
    end
    tick();
    job_valid = 1'b0; res_ready = 1'b0;
    n_vec++;
    if (job_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept: ready=%b want 0", job_ready);
    end
    tick();
    n_vec++;
    if (InstructionPacket !== 16'hA006) begin
      n_err++; $display("FAIL b2b_w0: pkt=%h want a006", InstructionPacket);
    end
    tick();
    n_vec++;
    if (InstructionPacket !== 16'h0000) begin
      n_err++; $display("FAIL b2b_w1: pkt=%h want 0000", InstructionPacket);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_packets();
    test_data_result();
    test_timeout();
    test_done_priority();
    test_reset_mid_send();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
